usb_desc_reader: RTL and testbench

Control-endpoint descriptor sequencer between the USB setup-request decoder and the EP0 IN transmit path. On a GET_DESCRIPTOR request it looks up the descriptor's offset and length in the descriptor ROM and drives the ROM address. It streams min(descriptor length, wLength) bytes as max-packet-size IN packets, rewinds on retry and terminates with a zero-length packet when required. Unknown descriptors produce a stall.

---
 rtl/usb_desc_reader_if.sv | 45 ++++
 rtl/usb_desc_reader.sv | 228 ++++++++++++++++++++++
 tb/tb_usb_desc_reader.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_desc_reader_if.sv
// rtl/usb_desc_reader_if.sv - request, descriptor ROM and EP0 IN transmit signals of usb_desc_reader
interface usb_desc_reader_if;
  // request side, from the setup-request decoder
  logic        hs_i;
  logic        req_valid_i;
  logic [7:0]  req_type_i;
  logic [7:0]  req_index_i;
  logic [15:0] req_length_i;
  logic        abort_i;
  // descriptor ROM, zero-wait combinational read
  logic [7:0]  rom_addr_o;
  logic [7:0]  rom_data_i;
  // EP0 IN transmit path
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_last_o;
  logic        tx_zlp_o;
  logic        tx_accept_i;
  logic        tx_ack_i;
  logic        tx_retry_i;
  // status
  logic        stall_o;
  logic        busy_o;
  logic        done_o;

  // descriptor sequencer side
  modport slave (
    input  hs_i, req_valid_i, req_type_i, req_index_i, req_length_i, abort_i,
    output rom_addr_o,
    input  rom_data_i,
    output tx_valid_o, tx_data_o, tx_last_o, tx_zlp_o,
    input  tx_accept_i, tx_ack_i, tx_retry_i,
    output stall_o, busy_o, done_o
  );

  // request decoder / ROM / transmit path side
  modport master (
    output hs_i, req_valid_i, req_type_i, req_index_i, req_length_i, abort_i,
    input  rom_addr_o,
    output rom_data_i,
    input  tx_valid_o, tx_data_o, tx_last_o, tx_zlp_o,
    output tx_accept_i, tx_ack_i, tx_retry_i,
    input  stall_o, busy_o, done_o
  );
endinterface

// File: rtl/usb_desc_reader.sv
// rtl/usb_desc_reader.sv - EP0 GET_DESCRIPTOR sequencer streaming ROM bytes as max-packet IN packets
module usb_desc_reader #(
  parameter logic [7:0]  DEV_OFS  = 8'd0,
  parameter logic [15:0] DEV_LEN  = 16'd18,
  parameter logic [7:0]  CFG_OFS  = 8'd18,
  parameter logic [15:0] CFG_LEN  = 16'd67,
  parameter logic [7:0]  STR0_OFS = 8'd85,
  parameter logic [15:0] STR0_LEN = 16'd4,
  parameter logic [7:0]  STR1_OFS = 8'd89,
  parameter logic [15:0] STR1_LEN = 16'd30,
  parameter logic [7:0]  STR2_OFS = 8'd119,
  parameter logic [15:0] STR2_LEN = 16'd30,
  parameter logic [7:0]  STR3_OFS = 8'd149,
  parameter logic [15:0] STR3_LEN = 16'd14
) (
  input logic              clk_i,
  input logic              rst_i,
  usb_desc_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  state_t      state;
  logic [6:0]  mps;
  logic [7:0]  rom_addr;
  logic [15:0] remaining;
  logic [6:0]  pkt_cnt;
  logic [7:0]  pkt_addr;
  logic [15:0] pkt_rem;
  logic [7:0]  sel_ofs;
  logic [15:0] sel_len;
  logic [15:0] wlength;
  logic        full;
  logic        short_xfer;
  logic        last_zlp;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_zlp;
  logic        stall;
  logic        busy;
  logic        done;

  logic        req_hit;
  logic [7:0]  req_ofs;
  logic [15:0] req_len;
  logic [15:0] xfer_len;
  logic [6:0]  mps_sel;
  logic        zlp_needed;

  // An item closes its packet when it is a ZLP, the final data byte, or fills the packet.
  function automatic logic item_last(input logic [6:0] cnt, input logic [15:0] rem,
                                     input logic [6:0] m);
    return (rem <= 16'd1) || (cnt == (m - 7'd1));
  endfunction

  // Map wValue to a ROM window; anything not listed is unsupported.
  always_comb begin
    req_hit = 1'b0;
    req_ofs = 8'd0;
    req_len = 16'd0;
    case (bus.req_type_i)
      8'd1: begin
        if (bus.req_index_i == 8'd0) begin
          req_hit = 1'b1;
          req_ofs = DEV_OFS;
          req_len = DEV_LEN;
        end
      end
      8'd2: begin
        if (bus.req_index_i == 8'd0) begin
          req_hit = 1'b1;
          req_ofs = CFG_OFS;
          req_len = CFG_LEN;
        end
      end
      8'd3: begin
        case (bus.req_index_i)
          8'd0: begin req_hit = 1'b1; req_ofs = STR0_OFS; req_len = STR0_LEN; end
          8'd1: begin req_hit = 1'b1; req_ofs = STR1_OFS; req_len = STR1_LEN; end
          8'd2: begin req_hit = 1'b1; req_ofs = STR2_OFS; req_len = STR2_LEN; end
          8'd3: begin req_hit = 1'b1; req_ofs = STR3_OFS; req_len = STR3_LEN; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign xfer_len   = (sel_len < wlength) ? sel_len : wlength;
  assign mps_sel    = bus.hs_i ? 7'd64 : 7'd8;
  // A short host-visible transfer that ended on a full packet needs a ZLP to terminate it.
  assign zlp_needed = full && short_xfer && !last_zlp;

  // Transfer sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      mps        <= 7'd0;
      rom_addr   <= 8'd0;
      remaining  <= 16'd0;
      pkt_cnt    <= 7'd0;
      pkt_addr   <= 8'd0;
      pkt_rem    <= 16'd0;
      sel_ofs    <= 8'd0;
      sel_len    <= 16'd0;
      wlength    <= 16'd0;
      full       <= 1'b0;
      short_xfer <= 1'b0;
      last_zlp   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_last    <= 1'b0;
      tx_zlp     <= 1'b0;
      stall      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (bus.abort_i) begin
      state    <= IDLE;
      pkt_cnt  <= 7'd0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      tx_zlp   <= 1'b0;
      stall    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      stall <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            if (req_hit) begin
              sel_ofs <= req_ofs;
              sel_len <= req_len;
              wlength <= bus.req_length_i;
              busy    <= 1'b1;
              state   <= LOAD;
            end else begin
              stall <= 1'b1;
            end
          end
        end
        LOAD: begin
          mps        <= mps_sel;
          rom_addr   <= sel_ofs;
          remaining  <= xfer_len;
          pkt_addr   <= sel_ofs;
          pkt_rem    <= xfer_len;
          pkt_cnt    <= 7'd0;
          full       <= 1'b0;
          last_zlp   <= 1'b0;
          short_xfer <= (sel_len < wlength);
          tx_valid   <= 1'b1;
          tx_zlp     <= (xfer_len == 16'd0);
          tx_last    <= item_last(7'd0, xfer_len, mps_sel);
          state      <= SEND;
        end
        SEND: begin
          if (bus.tx_accept_i) begin
            if (remaining == 16'd0) begin
              last_zlp <= 1'b1;
              full     <= 1'b0;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              tx_zlp   <= 1'b0;
              state    <= WAIT;
            end else begin
              rom_addr  <= rom_addr + 8'd1;
              remaining <= remaining - 16'd1;
              if (tx_last) begin
                full     <= ((pkt_cnt + 7'd1) == mps);
                last_zlp <= 1'b0;
                pkt_cnt  <= 7'd0;
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
                state    <= WAIT;
              end else begin
                pkt_cnt <= pkt_cnt + 7'd1;
                tx_last <= item_last(pkt_cnt + 7'd1, remaining - 16'd1, mps);
              end
            end
          end
        end
        WAIT: begin
          if (bus.tx_ack_i) begin
            if (remaining != 16'd0) begin
              pkt_addr <= rom_addr;
              pkt_rem  <= remaining;
              tx_valid <= 1'b1;
              tx_zlp   <= 1'b0;
              tx_last  <= item_last(7'd0, remaining, mps);
              state    <= SEND;
            end else if (zlp_needed) begin
              pkt_addr <= rom_addr;
              pkt_rem  <= 16'd0;
              tx_valid <= 1'b1;
              tx_zlp   <= 1'b1;
              tx_last  <= 1'b1;
              state    <= SEND;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (bus.tx_retry_i) begin
            rom_addr  <= pkt_addr;
            remaining <= pkt_rem;
            pkt_cnt   <= 7'd0;
            tx_valid  <= 1'b1;
            tx_zlp    <= (pkt_rem == 16'd0);
            tx_last   <= item_last(7'd0, pkt_rem, mps);
            state     <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr_o = rom_addr;
  assign bus.tx_valid_o = tx_valid;
  assign bus.tx_data_o  = bus.rom_data_i;
  assign bus.tx_last_o  = tx_last;
  assign bus.tx_zlp_o   = tx_zlp;
  assign bus.stall_o    = stall;
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;

endmodule

// File: tb/tb_usb_desc_reader.sv
// tb/tb_usb_desc_reader.sv - scoreboard bench for usb_desc_reader
module tb_usb_desc_reader;

  localparam int K_DATA  = 0;
  localparam int K_DONE  = 1;
  localparam int K_STALL = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    bit         last;
    bit         zlp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        hs = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_type = 8'd0;
  logic [7:0]  req_index = 8'd0;
  logic [15:0] req_length = 16'd0;
  logic        abort = 1'b0;
  logic        tx_accept = 1'b0;
  logic        tx_ack = 1'b0;
  logic        tx_retry = 1'b0;
  logic [7:0]  rom [256];

  usb_desc_reader_if ifa ();
  usb_desc_reader_if ifb ();

  assign ifa.hs_i         = hs;
  assign ifa.req_valid_i  = req_valid & ~sel;
  assign ifa.req_type_i   = req_type;
  assign ifa.req_index_i  = req_index;
  assign ifa.req_length_i = req_length;
  assign ifa.abort_i      = abort;
  assign ifa.rom_data_i   = rom[ifa.rom_addr_o];
  assign ifa.tx_accept_i  = tx_accept & ~sel;
  assign ifa.tx_ack_i     = tx_ack & ~sel;
  assign ifa.tx_retry_i   = tx_retry & ~sel;

  assign ifb.hs_i         = hs;
  assign ifb.req_valid_i  = req_valid & sel;
  assign ifb.req_type_i   = req_type;
  assign ifb.req_index_i  = req_index;
  assign ifb.req_length_i = req_length;
  assign ifb.abort_i      = abort;
  assign ifb.rom_data_i   = rom[ifb.rom_addr_o];
  assign ifb.tx_accept_i  = tx_accept & sel;
  assign ifb.tx_ack_i     = tx_ack & sel;
  assign ifb.tx_retry_i   = tx_retry & sel;

  usb_desc_reader u_dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  usb_desc_reader #(.STR3_LEN(16'd16)) u_dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb.slave));

  wire       tx_valid_m = sel ? ifb.tx_valid_o : ifa.tx_valid_o;
  wire [7:0] tx_data_m  = sel ? ifb.tx_data_o  : ifa.tx_data_o;
  wire       tx_last_m  = sel ? ifb.tx_last_o  : ifa.tx_last_o;
  wire       tx_zlp_m   = sel ? ifb.tx_zlp_o   : ifa.tx_zlp_o;
  wire       stall_m    = sel ? ifb.stall_o    : ifa.stall_o;
  wire       busy_m     = sel ? ifb.busy_o     : ifa.busy_o;
  wire       done_m     = sel ? ifb.done_o     : ifa.done_o;
  wire [7:0] rom_addr_m = sel ? ifb.rom_addr_o : ifa.rom_addr_o;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: no matching expectation or timeout", name);
  endtask

  // Scoreboard: pops one expectation per accepted item, done pulse or stall pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (tx_valid_m && tx_accept) begin
        if (q.size() == 0) miss("unexpected_item");
        else begin
          e = q.pop_front();
          check("item_kind", K_DATA, e.kind);
          check("item_zlp", tx_zlp_m, e.zlp);
          check("item_last", tx_last_m, e.last);
          if (!e.zlp) check("item_data", tx_data_m, e.data);
        end
      end
      if (done_m) begin
        if (q.size() == 0) miss("unexpected_done");
        else begin
          e = q.pop_front();
          check("done_kind", K_DONE, e.kind);
        end
      end
      if (stall_m) begin
        if (q.size() == 0) miss("unexpected_stall");
        else begin
          e = q.pop_front();
          check("stall_kind", K_STALL, e.kind);
        end
      end
    end
  end

  task automatic push_ev(input int kind);
    exp_t e;
    e.kind = kind; e.data = 8'd0; e.last = 1'b0; e.zlp = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_byte(input int a, input bit last);
    exp_t e;
    e.kind = K_DATA; e.data = rom[8'(a)]; e.last = last; e.zlp = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_pkt(input int a, input int n);
    exp_t e;
    if (n == 0) begin
      e.kind = K_DATA; e.data = 8'd0; e.last = 1'b1; e.zlp = 1'b1;
      q.push_back(e);
    end else begin
      for (int i = 0; i < n; i++) push_byte(a + i, i == n - 1);
    end
  endtask

  // Called just after a posedge; accepts n items and returns just after the posedge taking the last.
  task automatic run_pkt(input int n);
    int cnt;
    int budget;
    cnt = 0;
    budget = 0;
    tx_accept = 1'b1;
    while (cnt < n && budget < 200) begin
      @(negedge clk);
      budget++;
      if (tx_valid_m) cnt++;
    end
    @(posedge clk); #1;
    tx_accept = 1'b0;
    if (cnt < n) miss("pkt_timeout");
  endtask

  task automatic ack_pulse(input bit ack, input bit retry);
    @(negedge clk);
    check("wait_valid", tx_valid_m, 1'b0);
    @(posedge clk); #1;
    tx_ack = ack; tx_retry = retry;
    @(posedge clk); #1;
    tx_ack = 1'b0; tx_retry = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, q.size(), 0);
  endtask

  task automatic start_req(input logic [7:0] typ, input logic [7:0] idx, input logic [15:0] wlen);
    @(posedge clk); #1;
    req_type = typ; req_index = idx; req_length = wlen; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic xfer(input bit use_b, input bit hs_v, input logic [7:0] typ,
                      input logic [7:0] idx, input logic [15:0] wlen, input int ofs,
                      input int np, input int s0, input int s1, input int s2,
                      input int retry_pkt, input bit both);
    int sz[3];
    int a;
    sz[0] = s0; sz[1] = s1; sz[2] = s2;
    a = ofs;
    sel = use_b;
    hs = hs_v;
    start_req(typ, idx, wlen);
    @(negedge clk);
    check("load_busy", busy_m, 1'b1);
    check("load_valid", tx_valid_m, 1'b0);
    @(negedge clk);
    check("first_valid", tx_valid_m, 1'b1);
    check("first_addr", rom_addr_m, ofs);
    @(posedge clk); #1;
    for (int p = 0; p < np; p++) begin
      push_pkt(a, sz[p]);
      run_pkt(sz[p] == 0 ? 1 : sz[p]);
      if (p == retry_pkt) begin
        ack_pulse(1'b0, 1'b1);
        push_pkt(a, sz[p]);
        run_pkt(sz[p] == 0 ? 1 : sz[p]);
        if (p == np - 1) push_ev(K_DONE);
        ack_pulse(1'b1, both);
      end else begin
        if (p == np - 1) push_ev(K_DONE);
        ack_pulse(1'b1, 1'b0);
      end
      a += sz[p];
    end
    drain("xfer_drain");
    check("idle_busy", busy_m, 1'b0);
  endtask

  task automatic stall_req(input logic [7:0] typ, input logic [7:0] idx);
    sel = 1'b0;
    push_ev(K_STALL);
    start_req(typ, idx, 16'd64);
    @(negedge clk);
    check("stall_pulse", stall_m, 1'b1);
    check("stall_busy", busy_m, 1'b0);
    @(negedge clk);
    check("stall_once", stall_m, 1'b0);
    check("stall_busy2", busy_m, 1'b0);
    drain("stall_drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
    rom[0]  = 8'h12; rom[1]  = 8'h01; rom[2]  = 8'h00; rom[3]  = 8'h02;
    rom[18] = 8'h09; rom[19] = 8'h02; rom[20] = 8'h43; rom[21] = 8'h00;
    rom[85] = 8'h04; rom[86] = 8'h03; rom[87] = 8'h09; rom[88] = 8'h04;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_m, 1'b0);
    check("rst_valid", tx_valid_m, 1'b0);
    check("rst_stall", stall_m, 1'b0);
    check("rst_done", done_m, 1'b0);
    check("rst_addr", rom_addr_m, 8'd0);
    check("rst_last", tx_last_m, 1'b0);

    // FS device descriptor, wLength 64: 8 + 8 + 2
    xfer(1'b0, 1'b0, 8'd1, 8'd0, 16'd64, 0, 3, 8, 8, 2, -1, 1'b0);
    // HS configuration set, wLength 0xFFFF: 64 + 3, no ZLP
    xfer(1'b0, 1'b1, 8'd2, 8'd0, 16'hFFFF, 18, 2, 64, 3, 0, -1, 1'b0);
    // FS configuration truncated to 9: 8 + 1
    xfer(1'b0, 1'b0, 8'd2, 8'd0, 16'd9, 18, 2, 8, 1, 0, -1, 1'b0);
    // HS language ID string, wLength 255: 4 bytes
    xfer(1'b0, 1'b1, 8'd3, 8'd0, 16'd255, 85, 1, 4, 0, 0, -1, 1'b0);
    // FS device descriptor, retry on packet 2, then ack together with retry
    xfer(1'b0, 1'b0, 8'd1, 8'd0, 16'd64, 0, 3, 8, 8, 2, 1, 1'b1);
    // wLength 0: single ZLP
    xfer(1'b0, 1'b0, 8'd1, 8'd0, 16'd0, 0, 1, 0, 0, 0, -1, 1'b0);
    // 16-byte serial string, FS, wLength 32: 8 + 8 + ZLP, ZLP retried once
    xfer(1'b1, 1'b0, 8'd3, 8'd3, 16'd32, 149, 3, 8, 8, 0, 2, 1'b0);
    // FS serial string on the default block: 8 + 6
    xfer(1'b0, 1'b0, 8'd3, 8'd3, 16'd100, 149, 2, 8, 6, 0, -1, 1'b0);

    stall_req(8'd6, 8'd0);
    stall_req(8'd3, 8'd4);

    // abort after three bytes of a FS device descriptor transfer
    sel = 1'b0;
    hs = 1'b0;
    push_byte(0, 1'b0);
    push_byte(1, 1'b0);
    push_byte(2, 1'b0);
    start_req(8'd1, 8'd0, 16'd64);
    @(negedge clk);
    check("abort_load_busy", busy_m, 1'b1);
    @(posedge clk); #1;
    run_pkt(3);
    check("abort_pre_valid", tx_valid_m, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_m, 1'b0);
    check("abort_valid", tx_valid_m, 1'b0);
    repeat (5) @(negedge clk);
    check("abort_done", done_m, 1'b0);
    drain("abort_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
